// File: rtl/scp_mem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, the
// full-word byte-enable pattern and the arbiter state encoding.
package scp_mem_pkg;

   localparam int unsigned AW_DEF  = 12;
   localparam int unsigned DW_DEF  = 32;
   localparam logic [3:0]  BE_WORD = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISS_CORE = 3'd1,
      ST_RSP_CORE = 3'd2,
      ST_ISS_DBG  = 3'd3,
      ST_RSP_DBG  = 3'd4
   } arb_state_t;

   // States in which a new access may be selected (the memory port is free
   // next cycle): idle, or the response cycle of the previous access.
   function automatic logic is_select_state(arb_state_t s);
      return (s == ST_IDLE) || (s == ST_RSP_CORE) || (s == ST_RSP_DBG);
   endfunction

endpackage

// File: rtl/dbg_age_counter.sv
// Saturating age counter for a pending debug request. Counts cycles in which
// the debug request is waiting; clear has priority over increment.
module dbg_age_counter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic sat_o
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] age_q;
   logic [CW-1:0] age_d;

   assign sat_o = (age_q >= CW'(MAX_WAIT));

   // Next age: clear, else count up until saturated.
   always_comb begin
      age_d = age_q;
      if (clr_i) begin
         age_d = '0;
      end else if (inc_i && !sat_o) begin
         age_d = age_q + CW'(1);
      end
   end

   // Age register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path
// and the debug readout port. One access at a time: an issue cycle drives the
// memory, the following cycle returns data and acks the requester. The core
// has priority; the age counter lets a starved debug read win eventually.
module dmem_arbiter
   import scp_mem_pkg::*;
#(
   parameter int unsigned AW           = AW_DEF,
   parameter int unsigned DW           = DW_DEF,
   parameter int unsigned DBG_MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [3:0]    core_be,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_ack,
   output logic          core_stall,
   input  logic          dbg_req,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_t    state_q;
   arb_state_t    state_d;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] core_rdata_q;
   logic [DW-1:0] dbg_rdata_q;

   logic core_ok;
   logic dbg_ok;
   logic age_sat;
   logic age_clr;
   logic age_inc;

   // A requester being acked this cycle is still holding its request; it must
   // not be picked again for the access that is already finishing.
   assign core_ok = core_req && (state_q != ST_RSP_CORE);
   assign dbg_ok  = dbg_req  && (state_q != ST_RSP_DBG);

   assign age_inc = dbg_req && (state_q != ST_ISS_DBG) && (state_q != ST_RSP_DBG);
   assign age_clr = !dbg_req || (state_d == ST_ISS_DBG);

   dbg_age_counter #(
      .MAX_WAIT (DBG_MAX_WAIT)
   ) u_age (
      .clk   (clk),
      .rst   (rst),
      .clr_i (age_clr),
      .inc_i (age_inc),
      .sat_o (age_sat)
   );

   assign core_stall = core_req && !core_ack;

   // Next state, memory port mux and response outputs.
   always_comb begin
      state_d    = state_q;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_be     = '0;
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      core_ack   = 1'b0;
      dbg_ack    = 1'b0;
      core_rdata = core_rdata_q;
      dbg_rdata  = dbg_rdata_q;

      case (state_q)
         ST_ISS_CORE: begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_be    = core_be;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            state_d   = ST_RSP_CORE;
         end
         ST_ISS_DBG: begin
            mem_en    = 1'b1;
            mem_be    = BE_WORD;
            mem_addr  = dbg_addr;
            mem_wdata = '0;
            state_d   = ST_RSP_DBG;
         end
         ST_RSP_CORE: begin
            core_ack   = 1'b1;
            core_rdata = mem_rdata;
         end
         ST_RSP_DBG: begin
            dbg_ack   = 1'b1;
            dbg_rdata = mem_rdata;
         end
         default: begin
         end
      endcase

      if (is_select_state(state_q)) begin
         if (dbg_ok && age_sat) begin
            state_d = ST_ISS_DBG;
         end else if (core_ok) begin
            state_d = ST_ISS_CORE;
         end else if (dbg_ok) begin
            state_d = ST_ISS_DBG;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Hold the last driven address/data and capture read data per requester.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         if (mem_en) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
         end
         if (state_q == ST_RSP_CORE) begin
            core_rdata_q <= mem_rdata;
         end
         if (state_q == ST_RSP_DBG) begin
            dbg_rdata_q <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural data memory, a cycle model of the
// arbitration rules checked every cycle, and directed scenarios with literal
// expectations.
module tb_dmem_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          core_req = 1'b0;
   logic          core_we = 1'b0;
   logic [3:0]    core_be = 4'h0;
   logic [AW-1:0] core_addr = '0;
   logic [DW-1:0] core_wdata = '0;
   logic [DW-1:0] core_rdata;
   logic          core_ack;
   logic          core_stall;
   logic          dbg_req = 1'b0;
   logic [AW-1:0] dbg_addr = '0;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_ack;
   logic          mem_en;
   logic          mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .AW           (AW),
      .DW           (DW),
      .DBG_MAX_WAIT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_be    (core_be),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_ack   (core_ack),
      .core_stall (core_stall),
      .dbg_req    (dbg_req),
      .dbg_addr   (dbg_addr),
      .dbg_rdata  (dbg_rdata),
      .dbg_ack    (dbg_ack),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Power-up contents: word i holds 0x1000_0000+i, except word 4 (0x010).
   function automatic logic [31:0] init_word(input logic [9:0] idx);
      if (idx == 10'd4) return 32'hDEADBEEF;
      return 32'h1000_0000 | {22'd0, idx};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // ---------------- environment memory (registered read) ----------------
   logic [31:0] env_mem [0:1023];
   bit          env_vld [0:1023];

   function automatic logic [31:0] env_rd(input logic [9:0] i);
      return env_vld[i] ? env_mem[i] : init_word(i);
   endfunction

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            env_mem[mem_addr[11:2]] <= merge(env_rd(mem_addr[11:2]), mem_wdata, mem_be);
            env_vld[mem_addr[11:2]] <= 1'b1;
         end else begin
            mem_rdata <= env_rd(mem_addr[11:2]);
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // Accesses move through a two-slot pipeline: the access picked in a cycle
   // is issued the next cycle and answered the cycle after. A pick is only
   // possible in a cycle that is not itself issuing.
   logic [31:0] ref_mem [0:1023];
   bit          ref_vld [0:1023];

   function automatic logic [31:0] ref_rd(input logic [9:0] i);
      return ref_vld[i] ? ref_mem[i] : init_word(i);
   endfunction

   initial begin : model
      int          m_iss, m_ack, m_age, pick;   // 0 none, 1 core, 2 debug
      logic [11:0] m_hold_addr, m_pend_addr, m_dpend_addr;
      logic [31:0] m_hold_wdata, m_pend_wdata, m_core_rd, m_dbg_rd;
      logic [3:0]  m_pend_be;
      bit          m_pend_we, m_core_known, crd_known, dok, cok;
      logic        e_en, e_we, e_cack, e_dack;
      logic [3:0]  e_be;
      logic [11:0] e_addr;
      logic [31:0] e_wdata, e_crd, e_drd;
      m_iss = 0; m_ack = 0; m_age = 0;
      m_hold_addr = 0; m_pend_addr = 0; m_dpend_addr = 0;
      m_hold_wdata = 0; m_pend_wdata = 0; m_core_rd = 0; m_dbg_rd = 0;
      m_pend_be = 0; m_pend_we = 0; m_core_known = 1;
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_iss = 0; m_ack = 0; m_age = 0;
            m_hold_addr = 0; m_hold_wdata = 0;
            m_core_rd = 0; m_dbg_rd = 0; m_core_known = 1;
         end
         e_en    = (m_iss != 0);
         e_we    = (m_iss == 1) && core_we;
         e_be    = (m_iss == 1) ? core_be : (m_iss == 2) ? 4'hF : 4'h0;
         e_addr  = (m_iss == 1) ? core_addr : (m_iss == 2) ? dbg_addr : m_hold_addr;
         e_wdata = (m_iss == 1) ? core_wdata : (m_iss == 2) ? 32'd0 : m_hold_wdata;
         e_cack  = (m_ack == 1);
         e_dack  = (m_ack == 2);
         e_crd   = e_cack ? ref_rd(m_pend_addr[11:2]) : m_core_rd;
         crd_known = e_cack ? !m_pend_we : m_core_known;
         e_drd   = e_dack ? ref_rd(m_dpend_addr[11:2]) : m_dbg_rd;

         chk("mdl_mem_en",    32'(mem_en),    32'(e_en));
         chk("mdl_mem_we",    32'(mem_we),    32'(e_we));
         chk("mdl_mem_be",    32'(mem_be),    32'(e_be));
         chk("mdl_mem_addr",  32'(mem_addr),  32'(e_addr));
         chk("mdl_mem_wdata", mem_wdata,      e_wdata);
         chk("mdl_core_ack",  32'(core_ack),  32'(e_cack));
         chk("mdl_dbg_ack",   32'(dbg_ack),   32'(e_dack));
         chk("mdl_core_stall", 32'(core_stall), 32'(core_req && !e_cack));
         chk("mdl_dbg_rdata", dbg_rdata,      e_drd);
         if (crd_known) chk("mdl_core_rdata", core_rdata, e_crd);

         if (rst) begin
            if (e_cack) $display("core ack addr=%h we=%0d rdata=%h t=%0t",
                                 m_pend_addr, m_pend_we, core_rdata, $time);
            if (e_dack) $display("dbg  ack addr=%h rdata=%h t=%0t", m_dpend_addr, dbg_rdata, $time);
            pick = 0;
            if (m_iss == 0) begin
               dok = dbg_req && (m_ack != 2);
               cok = core_req && (m_ack != 1);
               if (dok && m_age >= 4) pick = 2;
               else if (cok)          pick = 1;
               else if (dok)          pick = 2;
            end
            if (!dbg_req || pick == 2) m_age = 0;
            else if (m_iss != 2 && m_ack != 2 && m_age < 4) m_age++;
            if (m_ack == 1) begin
               if (m_pend_we) begin
                  ref_mem[m_pend_addr[11:2]] = merge(ref_rd(m_pend_addr[11:2]), m_pend_wdata, m_pend_be);
                  ref_vld[m_pend_addr[11:2]] = 1'b1;
                  m_core_known = 0;
               end else begin
                  m_core_rd = e_crd;
                  m_core_known = 1;
               end
            end
            if (m_ack == 2) m_dbg_rd = e_drd;
            if (m_iss == 1) begin
               m_pend_addr = core_addr; m_pend_we = core_we;
               m_pend_be = core_be;     m_pend_wdata = core_wdata;
            end
            if (m_iss == 2) m_dpend_addr = dbg_addr;
            if (m_iss != 0) begin
               m_hold_addr = e_addr; m_hold_wdata = e_wdata;
            end
            m_ack = m_iss;
            m_iss = pick;
         end
      end
   end

   // ---------------- directed scenarios ----------------
   initial begin : stim
      int cyc, dcnt, ccnt;
      bit got;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_core_ack", 32'(core_ack), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_core_rdata", core_rdata, 0);
      tick(); rst = 1'b1;
      tick();

      // core load of 0x010
      core_req = 1'b1; core_we = 1'b0; core_addr = 12'h010;
      @(negedge clk);
      chk("ld_stall_c0", 32'(core_stall), 1);
      chk("ld_en_c0", 32'(mem_en), 0);
      tick(); @(negedge clk);
      chk("ld_en_c1", 32'(mem_en), 1);
      chk("ld_addr_c1", 32'(mem_addr), 32'h010);
      chk("ld_stall_c1", 32'(core_stall), 1);
      tick(); @(negedge clk);
      chk("ld_ack_c2", 32'(core_ack), 1);
      chk("ld_rdata_c2", core_rdata, 32'hDEADBEEF);
      chk("ld_stall_c2", 32'(core_stall), 0);
      tick(); core_req = 1'b0;
      @(negedge clk);
      chk("ld_ack_c3", 32'(core_ack), 0);
      chk("ld_rdata_hold", core_rdata, 32'hDEADBEEF);
      tick();

      // core store to 0x022, upper half-word
      core_req = 1'b1; core_we = 1'b1; core_be = 4'b1100;
      core_addr = 12'h022; core_wdata = 32'hABCD0000;
      tick(); @(negedge clk);
      chk("st_en", 32'(mem_en), 1);
      chk("st_we", 32'(mem_we), 1);
      chk("st_be", 32'(mem_be), 32'hC);
      chk("st_addr", 32'(mem_addr), 32'h022);
      chk("st_wdata", mem_wdata, 32'hABCD0000);
      tick(); @(negedge clk);
      chk("st_ack", 32'(core_ack), 1);
      chk("st_no_dbg_ack", 32'(dbg_ack), 0);
      tick(); core_req = 1'b0; core_we = 1'b0; core_be = 4'h0;
      @(negedge clk);
      chk("st_idle_we", 32'(mem_we), 0);
      chk("st_idle_be", 32'(mem_be), 0);
      chk("st_idle_addr_hold", 32'(mem_addr), 32'h022);
      tick();

      // read back the merged word
      core_req = 1'b1; core_addr = 12'h020;
      tick(); tick(); @(negedge clk);
      chk("rb_ack", 32'(core_ack), 1);
      chk("rb_rdata", core_rdata, 32'hABCD0008);
      tick(); core_req = 1'b0;
      tick();

      // simultaneous core and debug requests from idle
      core_req = 1'b1; core_addr = 12'h040; dbg_req = 1'b1; dbg_addr = 12'h004;
      tick(); @(negedge clk);
      chk("sim_core_first", 32'(mem_addr), 32'h040);
      tick(); @(negedge clk);
      chk("sim_core_ack", 32'(core_ack), 1);
      chk("sim_core_rdata", core_rdata, 32'h10000010);
      chk("sim_dbg_not_yet", 32'(dbg_ack), 0);
      tick(); core_req = 1'b0;
      @(negedge clk);
      chk("sim_dbg_en", 32'(mem_en), 1);
      chk("sim_dbg_addr", 32'(mem_addr), 32'h004);
      chk("sim_dbg_be", 32'(mem_be), 32'hF);
      chk("sim_dbg_wdata", mem_wdata, 0);
      tick(); @(negedge clk);
      chk("sim_dbg_ack", 32'(dbg_ack), 1);
      chk("sim_dbg_core_ack", 32'(core_ack), 0);
      chk("sim_dbg_rdata", dbg_rdata, 32'h10000001);
      tick(); dbg_req = 1'b0;
      tick();

      // core held continuously, debug joins one cycle later
      core_req = 1'b1; core_addr = 12'h100;
      tick(); dbg_req = 1'b1; dbg_addr = 12'h004;
      cyc = 0; got = 0;
      while (!got && cyc < 12) begin
         @(negedge clk);
         if (dbg_ack) got = 1;
         else begin tick(); cyc++; end
      end
      chk("stv_dbg_ack_seen", 32'(got), 1);
      chk("stv_dbg_latency", 32'(cyc), 3);
      chk("stv_dbg_rdata", dbg_rdata, 32'h10000001);
      tick(); dbg_req = 1'b0;
      dcnt = 0; ccnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dbg_ack) dcnt++;
         if (core_ack) ccnt++;
         tick();
      end
      chk("stv_single_dbg", 32'(dcnt), 0);
      chk("stv_core_resumes", 32'(ccnt), 3);
      chk("stv_core_rdata", core_rdata, 32'h10000040);
      core_req = 1'b0;
      repeat (3) tick();

      // reset pulse during a core issue cycle
      core_req = 1'b1; core_addr = 12'h030;
      tick(); @(negedge clk);
      chk("rsti_iss_en", 32'(mem_en), 1);
      #2 rst = 1'b0;
      #1;
      chk("rsti_en_0", 32'(mem_en), 0);
      chk("rsti_addr_0", 32'(mem_addr), 0);
      chk("rsti_wdata_0", mem_wdata, 0);
      chk("rsti_crd_0", core_rdata, 0);
      chk("rsti_drd_0", dbg_rdata, 0);
      tick(); @(negedge clk);
      chk("rsti_no_ack", 32'(core_ack), 0);
      tick(); rst = 1'b1;
      cyc = 0; got = 0;
      while (!got && cyc < 6) begin
         @(negedge clk);
         if (core_ack) got = 1;
         else begin tick(); cyc++; end
      end
      chk("rsti_reissue_ack", 32'(got), 1);
      chk("rsti_reissue_latency", 32'(cyc), 2);
      chk("rsti_reissue_rdata", core_rdata, 32'h1000000C);
      tick(); core_req = 1'b0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

endmodule
